// File: rtl/feistel_pkg.sv
// Shared constants for the Magma (GOST R 34.12-2015) Feistel round cell:
// widths, the eight 4-bit S-boxes and the g-function rotate amount.
package feistel_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 32;
  localparam int HALF_W  = BLOCK_W / 2;
  localparam int ROT     = 11;
  localparam int NIBBLES = HALF_W / 4;

  // SBOX[i][v] is Pi_i applied to nibble value v; nibble 0 is bits [3:0].
  localparam logic [3:0] SBOX [NIBBLES][16] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  // Circular left rotate of a half-block by ROT bits.
  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x);
    return (x << ROT) | (x >> (HALF_W - ROT));
  endfunction

endpackage

// File: rtl/feistel_gfunc.sv
// Combinational Magma round function g(K, a) = rotl11(t((a + K) mod 2^32)).
module feistel_gfunc
  import feistel_pkg::*;
(
  input  logic [KEY_W-1:0]  key,
  input  logic [HALF_W-1:0] a,
  output logic [HALF_W-1:0] g
);

  logic [HALF_W-1:0] sum;
  logic [HALF_W-1:0] subst;

  // Carry out of bit 31 falls off by width truncation.
  assign sum = a + key;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    subst = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      subst[4*i +: 4] = SBOX[i][sum[4*i +: 4]];
    end
  end

  assign g = rotl(subst);

endmodule

// File: rtl/feistel_cell.sv
// Registered single Magma Feistel round. Define FEISTEL_CELL_INV_EN to honour
// dir and build the inverse round; otherwise dir is ignored (forward only).
module feistel_cell
  import feistel_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [BLOCK_W-1:0] in,
  input  logic [KEY_W-1:0]   key,
  input  logic               dir,
  output logic [BLOCK_W-1:0] out,
  output logic               out_valid
);

  logic [HALF_W-1:0]  a1;
  logic [HALF_W-1:0]  a0;
  logic [HALF_W-1:0]  g_in;
  logic [HALF_W-1:0]  g_out;
  logic [BLOCK_W-1:0] next_out;

  assign a1 = in[BLOCK_W-1:HALF_W];
  assign a0 = in[HALF_W-1:0];

`ifdef FEISTEL_CELL_INV_EN
  // A single g instance serves both directions; only its data input is muxed.
  assign g_in = dir ? a1 : a0;

  always_comb begin
    next_out = {a0, a1 ^ g_out};
    if (dir) begin
      next_out = {a0 ^ g_out, a1};
    end
  end
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign g_in       = a0;
  assign next_out   = {a0, a1 ^ g_out};
`endif

  feistel_gfunc u_gfunc (
    .key (key),
    .a   (g_in),
    .g   (g_out)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= next_out;
      end
    end
  end

endmodule

// File: tb/tb_feistel_cell.sv
// Directed and randomized bench for feistel_cell (forward, inverse when
// FEISTEL_CELL_INV_EN is defined, round trip, reset and valid handling).
module tb_feistel_cell;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in;
  logic [31:0] key;
  logic        dir;
  logic [63:0] out;
  logic        out_valid;

  int total;
  int bad;

  feistel_cell dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .key       (key),
    .dir       (dir),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference g: each S-box row packed as 16 nibbles, Pi(0) first.
  function automatic logic [31:0] model_g(input logic [31:0] k, input logic [31:0] a);
    logic [63:0] rows [8];
    logic [31:0] s;
    logic [31:0] t;
    rows[0] = 64'hC462A5B9E8D703F1;
    rows[1] = 64'h68239A5C1E47BD0F;
    rows[2] = 64'hB3582FADE174C960;
    rows[3] = 64'hC821D4F670A53E9B;
    rows[4] = 64'h7F5A816D093EB42C;
    rows[5] = 64'h5DF692CAB78143E0;
    rows[6] = 64'h8E25691CF4B0DA37;
    rows[7] = 64'h17ED05834FA69CB2;
    s = a + k;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      t[4*i +: 4] = rows[i][63 - 4*s[4*i +: 4] -: 4];
    end
    return {t[20:0], t[31:21]};
  endfunction

  // Drive one cycle of inputs, then sample at the following falling edge.
  task automatic step(input logic v, input logic [63:0] blk, input logic [31:0] k, input logic d);
    in_valid = v;
    in       = blk;
    key      = k;
    dir      = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in       = '0;
    key      = '0;
    dir      = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out !== 64'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%h valid=%b, want out=0 valid=0", out, out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward;
    step(1'b1, 64'h00000000_FEDCBA98, 32'h87654321, 1'b0);
    total++;
    if (out !== 64'hFEDCBA98_FDCBC20C || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL forward: out=%h valid=%b, want FEDCBA98FDCBC20C valid=1", out, out_valid);
    end
    step(1'b0, '0, '0, 1'b0);
  endtask

`ifdef FEISTEL_CELL_INV_EN
  task automatic test_inverse;
    step(1'b1, 64'hFEDCBA98_FDCBC20C, 32'h87654321, 1'b1);
    total++;
    if (out !== 64'h00000000_FEDCBA98 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL inverse: out=%h valid=%b, want 00000000FEDCBA98 valid=1", out, out_valid);
    end
  endtask
`else
  task automatic test_dir_ignored;
    step(1'b1, 64'h00000000_FEDCBA98, 32'h87654321, 1'b1);
    total++;
    if (out !== 64'hFEDCBA98_FDCBC20C || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL dir_ignored: out=%h valid=%b, want FEDCBA98FDCBC20C", out, out_valid);
    end
  endtask
`endif

  task automatic test_chain;
    logic [31:0] keys [3];
    logic [31:0] a0s  [3];
    logic [31:0] exps [3];
    keys = '{32'hFDCBC20C, 32'h7E791A4B, 32'hC76549EC};
    a0s  = '{32'h87654321, 32'hFDCBC20C, 32'h7E791A4B};
    exps = '{32'h7E791A4B, 32'hC76549EC, 32'h9791C849};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, {32'h0, a0s[i]}, keys[i], 1'b0);
      total++;
      if (out !== {a0s[i], exps[i]}) begin
        bad++;
        $display("FAIL chain_g[%0d]: out=%h want %h", i, out, {a0s[i], exps[i]});
      end
    end
  endtask

  // Forward through the DUT, then undo it (DUT inverse when built, else model).
  task automatic round_trip(input logic [63:0] x, input logic [31:0] k, input int idx);
    logic [63:0] fwd;
    logic [63:0] back;
    step(1'b1, x, k, 1'b0);
    fwd = out;
`ifdef FEISTEL_CELL_INV_EN
    step(1'b1, fwd, k, 1'b1);
    back = out;
`else
    back = {fwd[31:0] ^ model_g(k, fwd[63:32]), fwd[63:32]};
`endif
    total++;
    if (back !== x) begin
      bad++;
      $display("FAIL round_trip[%0d]: got=%h want=%h key=%h", idx, back, x, k);
    end
  endtask

  task automatic test_round_trip;
    round_trip(64'hDEADBEEF_BAADF00D, 32'h01234567, -1);
    for (int i = 0; i < 1000; i++) begin
      round_trip({$urandom, $urandom}, $urandom, i);
    end
    step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_stream;
    in_valid = 1'b1;
    in       = 64'h00000000_FEDCBA98;
    key      = 32'h87654321;
    dir      = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 64'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out=%h valid=%b, want 0/0", out, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, {32'h0, 32'h87654321}, 32'hFDCBC20C, 1'b0);
    total++;
    if (out !== 64'h87654321_7E791A4B || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: out=%h valid=%b, want 876543217E791A4B", out, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] blks [3];
    logic [31:0] keys [3];
    logic [63:0] exps [3];
    blks = '{64'h00000000_FEDCBA98, 64'h00000000_FDCBC20C, 64'h00000000_7E791A4B};
    keys = '{32'h87654321, 32'h7E791A4B, 32'hC76549EC};
    exps = '{64'hFEDCBA98_FDCBC20C, 64'hFDCBC20C_C76549EC, 64'h7E791A4B_9791C849};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, blks[i], keys[i], 1'b0);
      total++;
      if (out !== exps[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL back_to_back[%0d]: out=%h valid=%b want %h", i, out, out_valid, exps[i]);
      end
    end
  endtask

  task automatic test_idle_hold;
    step(1'b0, 64'h1111_2222_3333_4444, 32'h55556666, 1'b0);
    total++;
    if (out !== 64'h7E791A4B_9791C849 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: out=%h valid=%b, want 7E791A4B9791C849 valid=0", out, out_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_forward;
`ifdef FEISTEL_CELL_INV_EN
    test_inverse;
`else
    test_dir_ignored;
`endif
    test_chain;
    test_round_trip;
    test_reset_mid_stream;
    test_back_to_back;
    test_idle_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
